// File: rtl/up_pkg.sv
// Shared constants and loader FSM state encoding for the up system
// program/data memory loader.
package up_pkg;

  localparam logic [7:0]  ACK            = 8'h06;
  localparam logic [7:0]  NAK            = 8'h15;
  localparam logic [7:0]  CMD_W          = 8'h57;
  localparam logic [7:0]  CMD_R          = 8'h52;
  localparam logic [7:0]  CMD_L          = 8'h4C;
  localparam logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_CNT,
    GET_DATA,
    WRITE,
    READ,
    RD_WAIT,
    SEND
  } state_t;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_W) || (b == CMD_R) || (b == CMD_L);
  endfunction

endpackage

// File: rtl/up_loader_timer.sv
// Inter-byte timeout counter: counts cycles while clear is low and
// saturates at LIMIT, where expired stays high until cleared.
module up_loader_timer
  import up_pkg::*;
#(
  parameter logic [23:0] LIMIT = TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic nRst,
  input  logic clear,
  output logic expired
);

  logic [23:0] count_reg;

  assign expired = (count_reg == LIMIT);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (!expired) begin
      count_reg <= count_reg + 24'd1;
    end
  end

endmodule

// File: rtl/up_loader_ctrl.sv
// UART-driven memory loader and memory-port arbiter: owns the memory port
// and holds the CPU in reset while prog is high, else passes the CPU through.
module up_loader_ctrl
  import up_pkg::*;
#(
  parameter logic [23:0] TIMEOUT = TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       prog,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       cpu_nRst,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  input  logic       cpu_we,
  input  logic       cpu_re,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       mem_re,
  input  logic [7:0] mem_rdata
);

  state_t     state_reg, state_next;
  logic [7:0] opcode_reg, opcode_next;
  logic [7:0] addr_reg, addr_next;
  logic [7:0] count_reg, count_next;
  logic [7:0] data_reg, data_next;
  logic [7:0] tx_data_reg, tx_data_next;
  logic       tx_start_reg, tx_start_next;
  logic       cpu_nrst_reg;
  logic       waiting_byte;
  logic       timer_clear;
  logic       timeout;

  assign waiting_byte = (state_reg == GET_ADDR) || (state_reg == GET_CNT) ||
                        (state_reg == GET_DATA);
  assign timer_clear  = rx_valid || !waiting_byte || !prog;

  up_loader_timer #(
    .LIMIT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .nRst   (nRst),
    .clear  (timer_clear),
    .expired(timeout)
  );

  // Port mux: prog selects the owner with no register stage in between.
  assign mem_addr  = prog ? addr_reg : cpu_addr;
  assign mem_wdata = prog ? data_reg : cpu_wdata;
  assign mem_we    = prog ? (state_reg == WRITE) : cpu_we;
  assign mem_re    = prog ? (state_reg == READ) : cpu_re;

  assign tx_start  = tx_start_reg;
  assign tx_data   = tx_data_reg;
  assign cpu_nRst  = cpu_nrst_reg;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_reg    <= IDLE;
      opcode_reg   <= '0;
      addr_reg     <= '0;
      count_reg    <= '0;
      data_reg     <= '0;
      tx_data_reg  <= '0;
      tx_start_reg <= 1'b0;
      cpu_nrst_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      opcode_reg   <= opcode_next;
      addr_reg     <= addr_next;
      count_reg    <= count_next;
      data_reg     <= data_next;
      tx_data_reg  <= tx_data_next;
      tx_start_reg <= tx_start_next;
      cpu_nrst_reg <= !prog && (state_reg == IDLE);
    end
  end

  always_comb begin
    state_next    = state_reg;
    opcode_next   = opcode_reg;
    addr_next     = addr_reg;
    count_next    = count_reg;
    data_next     = data_reg;
    tx_data_next  = tx_data_reg;
    tx_start_next = 1'b0;
    if (!prog) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rx_valid) begin
            if (is_cmd(rx_data)) begin
              opcode_next = rx_data;
              state_next  = GET_ADDR;
            end else begin
              tx_data_next = NAK;
              state_next   = SEND;
            end
          end
        end
        GET_ADDR: begin
          if (rx_valid) begin
            addr_next = rx_data;
            if (opcode_reg == CMD_W)      state_next = GET_DATA;
            else if (opcode_reg == CMD_R) state_next = READ;
            else                          state_next = GET_CNT;
          end else if (timeout) begin
            tx_data_next = NAK;
            state_next   = SEND;
          end
        end
        GET_CNT: begin
          if (rx_valid) begin
            count_next = rx_data;
            state_next = GET_DATA;
          end else if (timeout) begin
            tx_data_next = NAK;
            state_next   = SEND;
          end
        end
        GET_DATA: begin
          if (rx_valid) begin
            data_next  = rx_data;
            state_next = WRITE;
          end else if (timeout) begin
            tx_data_next = NAK;
            state_next   = SEND;
          end
        end
        WRITE: begin
          if (opcode_reg == CMD_L) begin
            addr_next  = addr_reg + 8'd1;
            count_next = count_reg - 8'd1;
            // A count of 0 wraps through 255 down to 1, giving 256 writes.
            if (count_reg == 8'd1) begin
              tx_data_next = ACK;
              state_next   = SEND;
            end else begin
              state_next = GET_DATA;
            end
          end else begin
            tx_data_next = ACK;
            state_next   = SEND;
          end
        end
        READ:    state_next = RD_WAIT;
        RD_WAIT: begin
          tx_data_next = mem_rdata;
          state_next   = SEND;
        end
        SEND: begin
          if (!tx_busy) begin
            tx_start_next = 1'b1;
            state_next    = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_up_loader_ctrl.sv
// Scoreboard bench for up_loader_ctrl: expected memory cycles and UART
// bytes are queued as commands are sent and matched as the DUT emits them.
module tb_up_loader_ctrl;

  localparam logic [23:0] TB_TIMEOUT = 24'd64;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       nRst;
  logic       prog;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       cpu_nRst;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_we;
  logic       cpu_re;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;

  logic [7:0] mem_model [256];
  logic [2:0] busy_cnt;

  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] exp_tx[$];

  int checks = 0;
  int fails  = 0;

  up_loader_ctrl #(
    .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk      (clk),
    .nRst     (nRst),
    .prog     (prog),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .cpu_nRst (cpu_nRst),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_we   (cpu_we),
    .cpu_re   (cpu_re),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory with one-cycle registered read, and a UART transmitter model
  // whose busy flag rises the cycle after tx_start.
  always @(posedge clk) begin
    if (mem_we) mem_model[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem_model[mem_addr];
  end

  always @(posedge clk or negedge nRst) begin
    if (!nRst)              busy_cnt <= 3'd0;
    else if (tx_start)      busy_cnt <= 3'd5;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 3'd1;
  end
  assign tx_busy = (busy_cnt != 3'd0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    wr_t        w;
    logic [7:0] b;
    if (nRst && prog && mem_we) begin
      if (exp_wr.size() == 0) check("we_unexpected", mem_we, 1'b0);
      else begin
        w = exp_wr.pop_front();
        $display("mem write addr=%02h data=%02h", mem_addr, mem_wdata);
        check("we_addr", mem_addr, w.addr);
        check("we_data", mem_wdata, w.data);
      end
    end
    if (nRst && prog && mem_re) begin
      if (exp_rd.size() == 0) check("re_unexpected", mem_re, 1'b0);
      else begin
        b = exp_rd.pop_front();
        $display("mem read  addr=%02h", mem_addr);
        check("re_addr", mem_addr, b);
      end
    end
    if (nRst && tx_start) begin
      if (exp_tx.size() == 0) check("tx_unexpected", tx_start, 1'b0);
      else begin
        b = exp_tx.pop_front();
        $display("uart tx   byte=%02h", tx_data);
        check("tx_data", tx_data, b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_wr.push_back(w);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_wr.size() + exp_rd.size() + exp_tx.size()) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (8) @(posedge clk);
    check("drain_left", exp_wr.size() + exp_rd.size() + exp_tx.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nRst = 1'b0; prog = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    cpu_addr = 8'h5A; cpu_wdata = 8'hC3; cpu_we = 1'b1; cpu_re = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_cpu_nrst", cpu_nRst, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_re", mem_re, 1'b0);
    cpu_we = 1'b0; cpu_re = 1'b0;
    nRst = 1'b1;
    repeat (2) @(posedge clk);

    // 1: single write
    push_wr(8'h10, 8'hA5);
    exp_tx.push_back(8'h06);
    send_byte(8'h57); send_byte(8'h10); send_byte(8'hA5);
    wait_drain(100);
    check("t1_cpu_nrst", cpu_nRst, 1'b0);

    // 2: single read of the byte just written
    exp_rd.push_back(8'h10);
    exp_tx.push_back(8'hA5);
    send_byte(8'h52); send_byte(8'h10);
    wait_drain(100);

    // 3: burst across the top of memory
    push_wr(8'hFE, 8'h11); push_wr(8'hFF, 8'h22); push_wr(8'h00, 8'h33);
    exp_tx.push_back(8'h06);
    send_byte(8'h4C); send_byte(8'hFE); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    wait_drain(100);
    check("t3_mem_00", mem_model[8'h00], 8'h33);
    check("t3_mem_ff", mem_model[8'hFF], 8'h22);

    // 4: burst abandoned part way, timeout NAK
    push_wr(8'h20, 8'h01); push_wr(8'h21, 8'h02);
    exp_tx.push_back(8'h15);
    send_byte(8'h4C); send_byte(8'h20); send_byte(8'h05);
    send_byte(8'h01); send_byte(8'h02);
    wait_drain(400);
    check("t4_mem_20", mem_model[8'h20], 8'h01);
    check("t4_mem_21", mem_model[8'h21], 8'h02);

    // 5: unknown opcode, then prog dropped mid-command
    exp_tx.push_back(8'h15);
    send_byte(8'h99);
    wait_drain(100);
    send_byte(8'h52);
    @(posedge clk); #1;
    cpu_addr = 8'h33; cpu_re = 1'b1;
    prog = 1'b0;
    #1;
    check("t5_mux_addr", mem_addr, 8'h33);
    check("t5_mux_re", mem_re, 1'b1);
    check("t5_cpu_nrst_hold", cpu_nRst, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("t5_cpu_nrst_rise", cpu_nRst, 1'b1);
    cpu_re = 1'b0;
    repeat (20) @(posedge clk);

    // 6: CPU pass-through, loader takeover, async reset mid-burst
    #1;
    cpu_addr = 8'h40; cpu_wdata = 8'h7E; cpu_we = 1'b1;
    #1;
    check("t6_mux_addr", mem_addr, 8'h40);
    check("t6_mux_wdata", mem_wdata, 8'h7E);
    check("t6_mux_we", mem_we, 1'b1);
    @(posedge clk); #1;
    prog = 1'b1;
    #1;
    check("t6_take_we", mem_we, 1'b0);
    @(posedge clk); #1;
    check("t6_take_cpu_nrst", cpu_nRst, 1'b0);
    cpu_we = 1'b0;
    push_wr(8'h80, 8'hAA);
    send_byte(8'h4C); send_byte(8'h80); send_byte(8'h04); send_byte(8'hAA);
    check("t6_burst_wr", exp_wr.size(), 0);
    @(posedge clk); #3;
    nRst = 1'b0;
    #1;
    check("t6_rst_tx_start", tx_start, 1'b0);
    check("t6_rst_tx_data", tx_data, 8'h00);
    check("t6_rst_cpu_nrst", cpu_nRst, 1'b0);
    check("t6_rst_mem_we", mem_we, 1'b0);
    @(posedge clk); #1;
    nRst = 1'b1;
    push_wr(8'h30, 8'h5C);
    exp_tx.push_back(8'h06);
    send_byte(8'h57); send_byte(8'h30); send_byte(8'h5C);
    wait_drain(100);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/up_loader_ctrl.md
Name: up_loader_ctrl

Overview:
Memory-port controller and arbiter for the up system. It owns the single 256x8 program/data memory port while prog is high and decodes a UART command stream (write, read, burst load) into memory cycles. It returns ACK/NAK/read data on the UART transmitter and holds the CPU in reset during programming. When prog is low, it passes the CPU memory port straight through.

Parameters:
ACK, 8'h06, byte sent after a completed write or burst
NAK, 8'h15, byte sent for an unknown command or a timeout
TIMEOUT, 24'd1_000_000, clk cycles allowed between bytes of one command
CMD_W, 8'h57, single-write opcode ('W')
CMD_R, 8'h52, single-read opcode ('R')
CMD_L, 8'h4C, burst-load opcode ('L')

Ports:
clk  in  1  system clock
nRst  in  1  asynchronous active-low reset
prog  in  1  programming mode request
rx_valid  in  1  one-cycle strobe, new UART byte
rx_data  in  8  received byte, valid with rx_valid
tx_busy  in  1  UART transmitter busy; asserts the cycle after tx_start
tx_start  out  1  one-cycle transmit request
tx_data  out  8  byte to transmit, held stable from tx_start
cpu_nRst  out  1  CPU/controller reset, active-low
cpu_addr  in  8  CPU address
cpu_wdata  in  8  CPU write data
cpu_we  in  1  CPU write enable
cpu_re  in  1  CPU read enable
mem_addr  out  8  memory address
mem_wdata  out  8  memory write data
mem_we  out  1  memory write enable
mem_re  out  1  memory read enable
mem_rdata  in  8  memory read data, valid 1 cycle after mem_re

Behaviour:
- Reset: state IDLE; tx_start=0; tx_data=0; cpu_nRst=0; internal addr, count and timer cleared; loader memory strobes 0.
- cpu_nRst is registered: it equals nRst & ~prog & (state==IDLE), delayed 1 cycle. The CPU therefore stays in reset for at least 1 cycle after prog falls.
- Arbitration: when prog=0, the mem_* outputs carry cpu_* combinationally. When prog=1, the loader owns the port and CPU strobes are ignored (mem_we/mem_re=0 except loader cycles).
- States: IDLE, GET_ADDR, GET_CNT, GET_DATA, WRITE, READ, RD_WAIT, SEND.
- IDLE, on rx_valid with prog=1:
  - CMD_W, CMD_R or CMD_L: go to GET_ADDR and latch the opcode.
  - Any other byte: load NAK and go to SEND.
- GET_ADDR, on rx_valid: latch addr.
  - W goes to GET_DATA.
  - R goes to READ.
  - L goes to GET_CNT.
- GET_CNT, on rx_valid: latch count. Count 0 means 256 bytes. Go to GET_DATA.
- GET_DATA, on rx_valid: latch data and go to WRITE.
- WRITE: assert mem_we for exactly 1 cycle with mem_addr=addr and mem_wdata=data.
  - For W: go to SEND with ACK.
  - For L: increment addr modulo 256 (255 wraps to 0) and decrement count. If count is exhausted, go to SEND with ACK; otherwise return to GET_DATA.
- READ: assert mem_re for 1 cycle, then RD_WAIT.
- RD_WAIT: capture mem_rdata into tx_data, go to SEND.
- SEND: wait for tx_busy=0, pulse tx_start for 1 cycle, then go to IDLE.
- rx_valid seen in WRITE, READ, RD_WAIT or SEND is discarded.
- Timeout: in GET_ADDR, GET_CNT or GET_DATA, the timer counts clk cycles since the last accepted byte. At TIMEOUT, load NAK and go to SEND; any burst writes already done remain in memory.
- prog falling in any state aborts immediately to IDLE on the next edge:
  - no further mem_we, and no tx_start unless already pulsed;
  - the port returns to the CPU in the same cycle prog reads 0.
- prog rising while the CPU is active: the loader takes the port on the same edge and cpu_nRst falls on the next edge.
- nRst low mid-operation: asynchronous return to reset values.

Decomposition:
- Shared package up_pkg holds:
  - the opcode constants CMD_W, CMD_R, CMD_L and the ACK/NAK bytes;
  - the state enum for the loader FSM.
- One natural sub-module: up_loader_timer, the resettable inter-byte timeout counter with a clear input and an expiry output.
- The port mux stays inline.

Test Plan:
1. prog=1; send 57,10,A5 -> one mem_we cycle with addr 10, data A5; tx_start with tx_data=06; cpu_nRst=0 throughout.
2. After test 1, send 52,10 -> mem_re at addr 10 -> tx_data=A5 one cycle after mem_re, then tx_start.
3. Send 4C,FE,03,11,22,33 -> writes FE=11, FF=22, 00=33 (wrap), then a single ACK 06.
4. Send 4C,20,05,01,02 then idle past TIMEOUT -> 20=01 and 21=02 written, NAK 15 sent, state IDLE.
5. Send 99 -> NAK 15, no memory access; send 52 then drop prog before the addr byte -> no tx_start, CPU port passes through, cpu_nRst rises 1 cycle later.
6. prog=0; CPU drives addr 40, wdata 7E, we=1 -> mem_* mirror it combinationally. Assert nRst=0 mid-burst -> all outputs return to reset values at once.
